// File: rtl/kulisch_acc_norm.sv
// Kulisch fixed-point dot-product accumulator. It sums carry-save beats into a wide
// two's-complement register, then rounds the total to IEEE-754 binary16 (RNE).
module kulisch_acc_norm #(
    parameter int unsigned AWIDTH = 91,
    parameter int unsigned FWIDTH = 48,
    parameter int unsigned LWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic [LWIDTH-1:0] i_len,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [AWIDTH-1:0] i_sum,
    input  logic [AWIDTH-1:0] i_carry,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [15:0]       o_fp16,
    output logic [AWIDTH-1:0] o_acc,
    output logic              o_ovf,
    output logic              o_busy
);

    localparam int unsigned PW = $clog2(AWIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_NORM = 2'd2,
        S_OUT  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [AWIDTH-1:0] acc_q, acc_d;
    logic [LWIDTH-1:0] cnt_q, cnt_d;
    logic [LWIDTH-1:0] len_q, len_d;
    logic              ovf_q, ovf_d;
    logic [15:0]       fp16_q, fp16_d;
    logic              ready_q, ready_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;

    logic              accept;
    logic              last_beat;
    logic [LWIDTH-1:0] cnt_inc;
    logic [AWIDTH-1:0] beat;
    logic [AWIDTH:0]   sum_ext;

    logic              sign;
    logic [AWIDTH-1:0] mag;
    logic [PW-1:0]     msb;
    logic [AWIDTH-2:0] norm;
    logic [4:0]        exp_f;
    logic [9:0]        mant;
    logic              guard;
    logic              sticky;
    logic              rnd_up;
    logic [14:0]       rounded;
    logic [15:0]       fp16_c;

    assign accept    = i_valid && ready_q;
    assign cnt_inc   = cnt_q + LWIDTH'(1);
    assign last_beat = (cnt_inc == len_q);
    assign beat      = i_sum + i_carry;
    assign sum_ext   = {acc_q[AWIDTH-1], acc_q} + {beat[AWIDTH-1], beat};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (i_start) state_d = (i_len != '0) ? S_ACC : S_NORM;
            S_ACC:  if (accept && last_beat) state_d = S_NORM;
            S_NORM: state_d = S_OUT;
            S_OUT:  if (valid_q && i_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake flags track the state being entered so they line up with state_q
    always_comb begin
        ready_d = (state_d == S_ACC);
        valid_d = (state_d == S_OUT);
        busy_d  = (state_d != S_IDLE);
    end

    // Accumulator, beat counter and sticky overflow
    always_comb begin
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        len_d  = len_q;
        ovf_d  = ovf_q;
        fp16_d = fp16_q;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    acc_d = '0;
                    cnt_d = '0;
                    ovf_d = 1'b0;
                    len_d = i_len;
                end
            end
            S_ACC: begin
                if (accept) begin
                    acc_d = sum_ext[AWIDTH-1:0];
                    cnt_d = cnt_inc;
                    ovf_d = ovf_q | (sum_ext[AWIDTH] ^ sum_ext[AWIDTH-1]);
                end
            end
            S_NORM: fp16_d = fp16_c;
            default: ;
        endcase
    end

    // Binary16 conversion of the final accumulator; |acc| of the most negative value fits unsigned
    always_comb begin
        sign = acc_q[AWIDTH-1];
        mag  = sign ? (~acc_q + AWIDTH'(1)) : acc_q;
        msb  = '0;
        for (int i = 0; i < AWIDTH; i++) begin
            if (mag[i]) msb = PW'(i);
        end
        norm = (AWIDTH-1)'(mag << (PW'(AWIDTH-1) - msb));

        if (msb >= PW'(FWIDTH-14)) begin
            exp_f  = 5'(msb - PW'(FWIDTH-15));
            mant   = norm[AWIDTH-2:AWIDTH-11];
            guard  = norm[AWIDTH-12];
            sticky = |norm[AWIDTH-13:0];
        end else begin
            exp_f  = 5'd0;
            mant   = mag[FWIDTH-15:FWIDTH-24];
            guard  = mag[FWIDTH-25];
            sticky = |mag[FWIDTH-26:0];
        end

        // Mantissa carry-out ripples into the exponent field (subnormal->normal, 30->inf)
        rnd_up  = guard && (sticky || mant[0]);
        rounded = {exp_f, mant} + 15'(rnd_up);

        if (mag == '0) begin
            fp16_c = 16'h0000;
        end else if (msb > PW'(FWIDTH+15)) begin
            fp16_c = {sign, 15'h7C00};
        end else begin
            fp16_c = {sign, rounded};
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            ovf_q   <= 1'b0;
            fp16_q  <= '0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            ovf_q   <= ovf_d;
            fp16_q  <= fp16_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign o_ready = ready_q;
    assign o_valid = valid_q;
    assign o_busy  = busy_q;
    assign o_ovf   = ovf_q;
    assign o_fp16  = fp16_q;
    assign o_acc   = acc_q;

endmodule

// File: tb/tb_kulisch_acc_norm.sv
// Directed bench for kulisch_acc_norm: latency, rounding, subnormals, overflow,
// output hold under back-pressure and asynchronous reset.
module tb_kulisch_acc_norm;

    localparam int unsigned AW = 91;
    localparam int unsigned LW = 8;

    logic          clk;
    logic          rst_n;
    logic          i_start;
    logic [LW-1:0] i_len;
    logic          i_valid;
    logic          o_ready;
    logic [AW-1:0] i_sum;
    logic [AW-1:0] i_carry;
    logic          o_valid;
    logic          i_ready;
    logic [15:0]   o_fp16;
    logic [AW-1:0] o_acc;
    logic          o_ovf;
    logic          o_busy;

    int checks   = 0;
    int failures = 0;

    localparam logic [AW-1:0] SPLIT = 91'h5A5_A5A5_1234_5678_9ABC;

    kulisch_acc_norm #(.AWIDTH(AW), .FWIDTH(48), .LWIDTH(LW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (i_start),
        .i_len   (i_len),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_sum   (i_sum),
        .i_carry (i_carry),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_fp16  (o_fp16),
        .o_acc   (o_acc),
        .o_ovf   (o_ovf),
        .o_busy  (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [AW-1:0] fx(input int sh);
        logic [AW-1:0] one;
        one = AW'(1);
        return one << sh;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic start(input logic [LW-1:0] len);
        i_start = 1'b1;
        i_len   = len;
        tick();
        i_start = 1'b0;
        i_len   = '0;
    endtask

    // Splits the beat value across sum/carry so the carry-save add is exercised
    task automatic beat(input string tag, input logic [AW-1:0] v);
        chk({tag, "_ready"}, 128'(o_ready), 128'(1));
        i_sum   = v + SPLIT;
        i_carry = AW'(0) - SPLIT;
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        i_sum   = '1;
        i_carry = '1;
    endtask

    task automatic release_out(input string tag);
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        chk({tag, "_idle_busy"}, 128'(o_busy), 128'(0));
        chk({tag, "_idle_valid"}, 128'(o_valid), 128'(0));
    endtask

    task automatic single(input string tag, input logic [AW-1:0] v, input logic [15:0] exp16);
        start(8'd1);
        beat(tag, v);
        chk({tag, "_norm_valid"}, 128'(o_valid), 128'(0));
        tick();
        chk({tag, "_out_valid"}, 128'(o_valid), 128'(1));
        chk({tag, "_fp16"}, 128'(o_fp16), 128'(exp16));
        chk({tag, "_acc"}, 128'(o_acc), 128'(v));
        release_out(tag);
    endtask

    initial begin
        rst_n   = 1'b1;
        i_start = 1'b0;
        i_len   = '0;
        i_valid = 1'b0;
        i_sum   = '0;
        i_carry = '0;
        i_ready = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_valid", 128'(o_valid), 128'(0));
        chk("rst_ready", 128'(o_ready), 128'(0));
        chk("rst_busy",  128'(o_busy),  128'(0));
        chk("rst_fp16",  128'(o_fp16),  128'(0));
        chk("rst_acc",   128'(o_acc),   128'(0));
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // 1.0 with two-cycle latency
        single("one", fx(48), 16'h3C00);

        // 1 + 1 - 0.5 + 0.25 with valid gaps
        start(8'd4);
        chk("dot_busy", 128'(o_busy), 128'(1));
        beat("dot_b0", fx(48));
        tick();
        beat("dot_b1", fx(48));
        tick();
        tick();
        beat("dot_b2", AW'(0) - fx(47));
        beat("dot_b3", fx(46));
        chk("dot_norm_valid", 128'(o_valid), 128'(0));
        tick();
        chk("dot_out_valid", 128'(o_valid), 128'(1));
        chk("dot_fp16", 128'(o_fp16), 128'(16'h3F00));
        chk("dot_ovf", 128'(o_ovf), 128'(0));
        chk("dot_acc", 128'(o_acc), 128'(fx(48) + fx(47) + fx(46)));
        release_out("dot");

        // Round-to-nearest-even and saturation to infinity
        single("rne_2051",  fx(59) + fx(49) + fx(48), 16'h6802);
        single("rne_65520", fx(64) - fx(52),           16'h7C00);
        single("rne_n65536", AW'(0) - fx(64),          16'hFC00);

        // Subnormals
        single("sub_1p24", fx(24),          16'h0001);
        single("sub_1p23", fx(23),          16'h0000);
        single("sub_3p22", fx(23) + fx(22), 16'h0001);
        single("sub_carry", fx(34) - fx(23), 16'h0400);

        // 2049.0 held under back-pressure while a stray i_start is presented
        start(8'd1);
        beat("hold", fx(59) + fx(48));
        tick();
        for (int k = 0; k < 5; k++) begin
            i_start = (k == 1);
            i_len   = 8'd3;
            tick();
            chk("hold_valid", 128'(o_valid), 128'(1));
            chk("hold_fp16",  128'(o_fp16),  128'(16'h6800));
            chk("hold_acc",   128'(o_acc),   128'(fx(59) + fx(48)));
        end
        i_start = 1'b0;
        i_len   = '0;
        release_out("hold");
        chk("hold_no_acc", 128'(o_ready), 128'(0));

        // Zero-length dot-product
        start(8'd0);
        chk("len0_norm_valid", 128'(o_valid), 128'(0));
        chk("len0_norm_ready", 128'(o_ready), 128'(0));
        tick();
        chk("len0_valid", 128'(o_valid), 128'(1));
        chk("len0_fp16",  128'(o_fp16),  128'(0));
        chk("len0_acc",   128'(o_acc),   128'(0));
        release_out("len0");

        // 2^89 + 2^89 wraps to -2^90
        start(8'd2);
        beat("ovf_b0", fx(89));
        chk("ovf_b0_flag", 128'(o_ovf), 128'(0));
        beat("ovf_b1", fx(89));
        chk("ovf_b1_flag", 128'(o_ovf), 128'(1));
        tick();
        chk("ovf_fp16", 128'(o_fp16), 128'(16'hFC00));
        chk("ovf_acc",  128'(o_acc),  128'(fx(90)));
        release_out("ovf");
        chk("ovf_held", 128'(o_ovf), 128'(1));

        // Reset mid-accumulation
        start(8'd4);
        chk("ovf_cleared", 128'(o_ovf), 128'(0));
        beat("mid_b0", fx(48));
        chk("mid_acc", 128'(o_acc), 128'(fx(48)));
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_acc",   128'(o_acc),   128'(0));
        chk("mid_rst_fp16",  128'(o_fp16),  128'(0));
        chk("mid_rst_ready", 128'(o_ready), 128'(0));
        chk("mid_rst_busy",  128'(o_busy),  128'(0));
        chk("mid_rst_valid", 128'(o_valid), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        i_sum   = fx(48);
        i_carry = '0;
        i_valid = 1'b1;
        tick();
        tick();
        i_valid = 1'b0;
        chk("post_rst_ready", 128'(o_ready), 128'(0));
        chk("post_rst_busy",  128'(o_busy),  128'(0));
        chk("post_rst_acc",   128'(o_acc),   128'(0));

        // Fresh run after reset still works
        single("post_rst_one", fx(48), 16'h3C00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/kulisch_acc_norm.md
KULISCH_ACC_NORM -- requirements
Module: kulisch_acc_norm

Interface
REQ-001 Parameter AWIDTH, default 91: width of the two's-complement Kulisch accumulator and of each carry-save input vector.
REQ-002 Parameter FWIDTH, default 48: number of fraction bits in the fixed-point format, so the LSB weight is 2^-48.
REQ-003 Parameter LWIDTH, default 8: width of the beat-count field.
REQ-004 clk  in  1  clock; all state updates on the rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 i_start  in  1  single-cycle pulse that begins one dot-product; sampled only in IDLE.
REQ-007 i_len  in  LWIDTH  number of beats to accumulate; captured together with i_start.
REQ-008 i_valid  in  1  i_sum/i_carry beat valid.
REQ-009 o_ready  out  1  block accepts a beat this cycle.
REQ-010 i_sum  in  AWIDTH  carry-save sum vector from the upstream adder tree.
REQ-011 i_carry  in  AWIDTH  carry-save carry vector from the upstream adder tree.
REQ-012 o_valid  out  1  result valid.
REQ-013 i_ready  in  1  downstream accepts the result.
REQ-014 o_fp16  out  16  accumulated result rounded to IEEE-754 binary16.
REQ-015 o_acc  out  AWIDTH  raw accumulator value; valid whenever o_valid=1.
REQ-016 o_ovf  out  1  sticky accumulator-overflow flag for the current dot-product.
REQ-017 o_busy  out  1  high in any state other than IDLE.

Function
REQ-018 The FSM SHALL have states IDLE, ACC, NORM and OUT.
REQ-019 Transitions SHALL be: IDLE->ACC on i_start with i_len!=0; IDLE->NORM on i_start with i_len==0; ACC->NORM on acceptance of the i_len-th beat; NORM->OUT after 1 cycle; OUT->IDLE when o_valid && i_ready.
REQ-020 On i_start in IDLE, acc, the beat counter and o_ovf SHALL clear to 0 and i_len SHALL be latched; i_start in any other state SHALL be ignored.
REQ-021 o_ready SHALL equal 1 only in ACC; a beat is accepted when i_valid && o_ready.
REQ-022 Each beat value b SHALL be (i_sum + i_carry) mod 2^AWIDTH, interpreted as signed; on acceptance, acc <= acc + b mod 2^AWIDTH.
REQ-023 o_ovf SHALL set when the (AWIDTH+1)-bit sign-extended sum acc+b has bit AWIDTH != bit AWIDTH-1, and SHALL hold until the next accepted i_start or reset.
REQ-024 NORM SHALL register sign = acc[AWIDTH-1], mag = |acc| (unsigned AWIDTH bits, so -2^(AWIDTH-1) is representable), and p = index of the MSB of mag.
REQ-025 Conversion with e = p - FWIDTH SHALL be:
  - mag=0 -> 0x0000;
  - e>15 -> sign|0x7C00;
  - e>=-14 -> normal: exp = e+15, mantissa = mag[p-1:p-10], guard = bit p-11, sticky = OR of lower bits;
  - e<-14 -> subnormal: mantissa = mag[FWIDTH-15:FWIDTH-24], exp field 0, guard = bit FWIDTH-25, sticky = OR of bits below.
REQ-026 Rounding SHALL be round-to-nearest-even. Mantissa carry-out SHALL increment the exponent (subnormal->0x0400, normal exp 30->31 gives infinity); a zero-magnitude rounded result keeps its sign bit.
REQ-027 Latency SHALL be: last beat accepted at cycle T -> o_valid=1 at T+2; i_start with i_len=0 at T -> o_valid at T+2.
REQ-028 In OUT, o_valid SHALL be 1 and o_fp16/o_acc SHALL hold stable until i_ready=1; o_valid SHALL be 0 in all other states.
REQ-029 i_sum/i_carry SHALL be ignored when o_ready=0.

Reset
REQ-030 When rst_n=0, at any time including mid-ACC or mid-OUT, the block SHALL enter IDLE with acc, counter, o_fp16, o_acc, o_ovf, o_valid, o_ready and o_busy all 0.
REQ-031 After reset release, the block SHALL need a new i_start before accepting beats.

Verification
REQ-032 len=1, sum=1<<48, carry=0 -> o_fp16=0x3C00, o_valid exactly 2 cycles after the beat.
REQ-033 len=4, beats 1.0, 1.0, -0.5, 0.25 (each split across sum/carry) with i_valid gaps -> 0x3F00, o_ovf=0.
REQ-034 RNE checks: 2049.0 -> 0x6800; 2051.0 -> 0x6802; 65520.0 -> 0x7C00; -65536.0 -> 0xFC00.
REQ-035 Subnormal checks: acc=1<<24 -> 0x0001; 1<<23 -> 0x0000; 3<<22 -> 0x0001; (2^-14 - 2^-25) -> 0x0400.
REQ-036 i_ready held low 5 cycles in OUT -> o_fp16 stable and a mid-OUT i_start ignored; len=0 -> 0x0000; rst_n pulsed mid-ACC -> all outputs 0 and IDLE.
REQ-037 Two beats of +2^89 each -> o_ovf=1, held until the next i_start.
